// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: arm, random wait, light LED, then gate 1 ms ticks into the BCD chain until stop.
// Latency: state and flags register on the clk edge after start/stop/tick; only cnt_enb is combinational.
module reaction_ctrl #(
  parameter int              DELAY_MIN_MS = 1000,
  parameter int              RANGE_BITS   = 11,
  parameter int              DLY_W        = 16,
  parameter logic [15:0]     LFSR_SEED    = 16'hACE1,
  parameter bit              RANDOM_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       tick_1ms,
  input  logic       cnt_ovf,
  output logic       cnt_clr,
  output logic       cnt_enb,
  output logic       led_on,
  output logic       done,
  output logic       early,
  output logic       timeout,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_REACT   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_EARLY   = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  localparam logic [DLY_W-1:0] DLY_ONE  = 1;
  localparam logic [DLY_W-1:0] DLY_BASE = DLY_W'(DELAY_MIN_MS);

  logic [2:0]       state_q, state_d;
  logic [15:0]      lfsr_q;
  logic [DLY_W-1:0] dly_q, dly_d, addend;
  logic             accept;
  logic             clr_q, led_q, done_q, early_q, timeout_q;

  assign addend  = RANDOM_EN ? DLY_W'(lfsr_q[RANGE_BITS-1:0]) : '0;
  assign cnt_enb = (state_q == S_REACT) && tick_1ms;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_EARLY, S_TIMEOUT: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_WAIT;
          dly_d   = DLY_BASE + addend;
        end
      end
      S_WAIT: begin
        // A press on the final tick still counts as early.
        if (stop) begin
          state_d = S_EARLY;
        end else if (tick_1ms) begin
          if (dly_q <= DLY_ONE) begin
            state_d = S_REACT;
            dly_d   = '0;
          end else begin
            dly_d = dly_q - DLY_ONE;
          end
        end
      end
      S_REACT: begin
        if (stop)
          state_d = S_DONE;
        else if (cnt_ovf && tick_1ms)
          state_d = S_TIMEOUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      dly_q     <= '0;
      clr_q     <= 1'b0;
      led_q     <= 1'b0;
      done_q    <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Taps 16,14,13,11; a nonzero seed never reaches the all-zero lockup state.
      lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      dly_q     <= dly_d;
      clr_q     <= accept;
      led_q     <= (state_d == S_REACT);
      done_q    <= (state_d == S_DONE);
      early_q   <= (state_d == S_EARLY);
      timeout_q <= (state_d == S_TIMEOUT);
    end
  end

  assign state   = state_q;
  assign cnt_clr = clr_q;
  assign led_on  = led_q;
  assign done    = done_q;
  assign early   = early_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with a fixed 5 ms delay and ticks every 4th clock.
module tb_reaction_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, tick_1ms, cnt_ovf;
  logic       cnt_clr, cnt_enb, led_on, done, early, timeout;
  logic [2:0] state;

  always #5 clk = ~clk;

  reaction_ctrl #(
    .DELAY_MIN_MS(5),
    .RANGE_BITS  (11),
    .DLY_W       (16),
    .LFSR_SEED   (16'hACE1),
    .RANDOM_EN   (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .tick_1ms(tick_1ms),
    .cnt_ovf (cnt_ovf),
    .cnt_clr (cnt_clr),
    .cnt_enb (cnt_enb),
    .led_on  (led_on),
    .done    (done),
    .early   (early),
    .timeout (timeout),
    .state   (state)
  );

  int checks = 0;
  int errors = 0;
  int enb_cnt = 0;
  int led_cnt = 0;

  always @(posedge clk) begin
    if (cnt_enb === 1'b1) enb_cnt <= enb_cnt + 1;
    if (led_on === 1'b1)  led_cnt <= led_cnt + 1;
  end

  // exp packs {cnt_enb, state[2:0], cnt_clr, led_on, done, early, timeout}
  typedef struct {
    int         idle;
    logic       s, st, tk, ov;
    logic [8:0] exp;
    bit         base;
    int         enb_chk;
    int         led_chk;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input int idle, input logic s, st, tk, ov,
                   input logic enb, input logic [2:0] stt,
                   input logic clr, led, dn, er, to);
    vec_t t;
    t.idle = idle; t.s = s; t.st = st; t.tk = tk; t.ov = ov;
    t.exp = {enb, stt, clr, led, dn, er, to};
    t.base = 1'b0; t.enb_chk = -1; t.led_chk = -1;
    vecs.push_back(t);
  endtask

  task automatic mark_base();
    vecs[vecs.size()-1].base = 1'b1;
  endtask

  task automatic mark_chk(input int enb_n, input int led_n);
    vecs[vecs.size()-1].enb_chk = enb_n;
    vecs[vecs.size()-1].led_chk = led_n;
  endtask

  task automatic check9(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got enb/state/clr/led/done/early/to=%b required %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, st, tk, ov);
    @(negedge clk);
    start = s; stop = st; tick_1ms = tk; cnt_ovf = ov;
  endtask

  function automatic logic [8:0] outs(input logic enb);
    return {enb, state, cnt_clr, led_on, done, early, timeout};
  endfunction

  // Four clocks per tick: three quiet clocks, then the tick on the vector cycle.
  task automatic build();
    // normal trial
    v(2, 0,0,0,0, 0, 3'd0, 0,0,0,0,0);
    v(0, 1,0,0,0, 0, 3'd1, 1,0,0,0,0); mark_base();
    v(0, 0,0,0,0, 0, 3'd1, 0,0,0,0,0);
    for (int i = 0; i < 4; i++) v(3, 0,0,1,0, 0, 3'd1, 0,0,0,0,0);
    v(3, 0,0,1,0, 0, 3'd2, 0,1,0,0,0);
    for (int i = 0; i < 7; i++) v(3, 0,0,1,0, 1, 3'd2, 0,1,0,0,0);
    v(2, 0,1,0,0, 0, 3'd3, 0,0,1,0,0); mark_chk(7, -1);
    v(1, 0,1,0,0, 0, 3'd3, 0,0,1,0,0);
    // early press, then restart from EARLY
    v(1, 1,0,0,0, 0, 3'd1, 1,0,0,0,0); mark_base();
    v(3, 0,0,1,0, 0, 3'd1, 0,0,0,0,0);
    v(3, 0,0,1,0, 0, 3'd1, 0,0,0,0,0);
    v(1, 0,1,0,0, 0, 3'd4, 0,0,0,1,0); mark_chk(0, 0);
    v(1, 1,0,0,0, 0, 3'd1, 1,0,0,0,0);
    // stop on the final WAIT tick
    for (int i = 0; i < 4; i++) v(3, 0,0,1,0, 0, 3'd1, 0,0,0,0,0);
    v(3, 0,1,1,0, 0, 3'd4, 0,0,0,1,0);
    // stop together with a REACT tick
    v(1, 1,0,0,0, 0, 3'd1, 1,0,0,0,0); mark_base();
    for (int i = 0; i < 4; i++) v(3, 0,0,1,0, 0, 3'd1, 0,0,0,0,0);
    v(3, 0,0,1,0, 0, 3'd2, 0,1,0,0,0);
    v(3, 0,0,1,0, 1, 3'd2, 0,1,0,0,0);
    v(3, 0,1,1,0, 1, 3'd3, 0,0,1,0,0); mark_chk(2, -1);
    // timeout, with ignored starts in WAIT and REACT
    v(1, 1,0,0,0, 0, 3'd1, 1,0,0,0,0);
    v(1, 1,0,0,0, 0, 3'd1, 0,0,0,0,0);
    for (int i = 0; i < 4; i++) v(3, 0,0,1,0, 0, 3'd1, 0,0,0,0,0);
    v(3, 0,0,1,0, 0, 3'd2, 0,1,0,0,0);
    v(0, 0,0,0,1, 0, 3'd2, 0,1,0,0,0);
    v(1, 1,0,0,0, 0, 3'd2, 0,1,0,0,0);
    v(2, 0,0,1,1, 1, 3'd5, 0,0,0,0,1);
    v(1, 0,1,0,0, 0, 3'd5, 0,0,0,0,1);
    v(1, 1,0,0,0, 0, 3'd1, 1,0,0,0,0);
    for (int i = 0; i < 4; i++) v(3, 0,0,1,0, 0, 3'd1, 0,0,0,0,0);
    v(3, 0,0,1,0, 0, 3'd2, 0,1,0,0,0);
  endtask

  initial begin
    int enb_base, led_base;
    logic enb_s;
    rst = 1'b1; start = 1'b0; stop = 1'b0; tick_1ms = 1'b0; cnt_ovf = 1'b0;
    enb_base = 0; led_base = 0;

    #2 rst = 1'b0;
    #1 check9("reset_async", outs(cnt_enb), 9'b0);
    repeat (2) @(posedge clk);
    #1 check9("reset_held", outs(cnt_enb), 9'b0);
    @(negedge clk) rst = 1'b1;

    build();
    foreach (vecs[i]) begin
      if (vecs[i].base) begin
        enb_base = enb_cnt;
        led_base = led_cnt;
      end
      repeat (vecs[i].idle) drive(0, 0, 0, 0);
      drive(vecs[i].s, vecs[i].st, vecs[i].tk, vecs[i].ov);
      #1 enb_s = cnt_enb;
      @(posedge clk);
      #1 check9($sformatf("vec%0d", i), outs(enb_s), vecs[i].exp);
      start = 1'b0; stop = 1'b0; tick_1ms = 1'b0; cnt_ovf = 1'b0;
      if (vecs[i].enb_chk >= 0)
        check_int($sformatf("enb_pulses_vec%0d", i), enb_cnt - enb_base, vecs[i].enb_chk);
      if (vecs[i].led_chk >= 0)
        check_int($sformatf("led_cycles_vec%0d", i), led_cnt - led_base, vecs[i].led_chk);
    end

    // Asynchronous reset while in REACT with a tick pending.
    @(negedge clk);
    tick_1ms = 1'b1;
    #1 check9("react_before_rst", outs(cnt_enb), {1'b1, 3'd2, 1'b0, 1'b1, 3'b000});
    rst = 1'b0;
    #1 check9("rst_mid_react", outs(cnt_enb), 9'b0);
    tick_1ms = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check9("idle_after_rst", outs(cnt_enb), 9'b0);
    drive(1, 0, 0, 0);
    @(posedge clk);
    #1 check9("start_after_rst", outs(cnt_enb), {1'b0, 3'd1, 1'b1, 4'b0000});
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
